// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the burst RAM slave: burst encodings,
// response codes and the burst legality check used by both channels.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // max_size is log2 of the bus width in bytes; larger beats cannot be served.
    function automatic logic burst_legal(
        input logic [1:0] burst,
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [2:0] max_size
    );
        logic legal;
        legal = (size <= max_size);
        case (burst)
            2'b00, 2'b01: begin
            end
            2'b10: begin
                if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// Per-channel burst address sequencer: holds the beat address and count,
// steps FIXED/INCR/WRAP addresses and exposes the RAM word index.
module axi4_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_LSB   = 4,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [7:0]            start_len,
    input  logic [2:0]            start_size,
    input  logic [1:0]            start_burst,
    input  logic                  advance,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [7:0]            len_reg;
    logic [7:0]            count_reg;
    logic [2:0]            size_reg;
    logic [1:0]            burst_reg;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_reg;
        wrap_mask = ((ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1)) << size_reg) - ADDR_WIDTH'(1);
        addr_next = addr_reg;
        case (burst_reg)
            // INCR realigns to the beat size so an unaligned start lands on the grid
            INCR:    addr_next = (addr_reg & ~(step - ADDR_WIDTH'(1))) + step;
            WRAP:    addr_next = (addr_reg & ~wrap_mask) | ((addr_reg + step) & wrap_mask);
            default: addr_next = addr_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            len_reg   <= '0;
            count_reg <= '0;
            size_reg  <= '0;
            burst_reg <= '0;
        end else if (load) begin
            addr_reg  <= start_addr;
            len_reg   <= start_len;
            count_reg <= '0;
            size_reg  <= start_size;
            burst_reg <= start_burst;
        end else if (advance) begin
            addr_reg  <= addr_next;
            count_reg <= count_reg + 8'd1;
        end
    end

    assign word = addr_reg[WORD_LSB +: WORD_WIDTH];
    assign last = (count_reg == len_reg);

endmodule

// File: rtl/axi4_burst_ram_slave.sv
// AXI4 burst slave in front of a byte-enabled simple dual-port block RAM;
// read and write channels run independent FSMs and address sequencers.
module axi4_burst_ram_slave
    import axi4_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 128,
    parameter int AXI_ID_WIDTH     = 16,
    parameter int MEM_DEPTH        = 256,
    parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_STROBE_WIDTH-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int         WORD_LSB   = $clog2(AXI_STROBE_WIDTH);
    localparam int         WORD_WIDTH = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE   = 3'(WORD_LSB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic                      rst_done_reg;
    w_state_t                  w_state_reg;
    logic                      werr_reg;
    logic                      wlast_err_reg;
    logic                      bvalid_reg;
    logic [1:0]                bresp_reg;
    logic [AXI_ID_WIDTH-1:0]   bid_reg;
    r_state_t                  r_state_reg;
    logic                      rerr_reg;
    logic                      rvalid_reg;
    logic [1:0]                rresp_reg;
    logic                      rlast_reg;
    logic [AXI_ID_WIDTH-1:0]   rid_reg;

    logic                      aw_hs;
    logic                      w_hs;
    logic                      ar_hs;
    logic                      wlast_bad;
    logic                      wen;
    logic                      ren;
    logic [WORD_WIDTH-1:0]     wgen_word;
    logic                      wgen_last;
    logic [WORD_WIDTH-1:0]     rgen_word;
    logic                      rgen_last;
    logic [AXI_DATA_WIDTH-1:0] ram_q;

    assign s_axi_awready = (w_state_reg == W_IDLE) && rst_done_reg;
    assign s_axi_wready  = (w_state_reg == W_DATA);
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_bid     = bid_reg;
    assign s_axi_arready = (r_state_reg == R_IDLE) && rst_done_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rresp   = rresp_reg;
    assign s_axi_rlast   = rlast_reg;
    assign s_axi_rid     = rid_reg;
    assign s_axi_rdata   = (rvalid_reg && !rerr_reg) ? ram_q : '0;

    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign wlast_bad = (s_axi_wlast != wgen_last);
    assign wen       = w_hs && !werr_reg;
    // The RAM read register only moves on the fetch or an accepted non-final beat,
    // which keeps rdata frozen through rready stalls.
    assign ren = (r_state_reg == R_FETCH) ||
                 ((r_state_reg == R_DATA) && s_axi_rready && !rlast_reg);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rst_done_reg <= 1'b0;
        end else begin
            rst_done_reg <= 1'b1;
        end
    end

    axi4_addr_gen #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .WORD_LSB   (WORD_LSB),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_wr_addr_gen (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .load        (aw_hs),
        .start_addr  (s_axi_awaddr),
        .start_len   (s_axi_awlen),
        .start_size  (s_axi_awsize),
        .start_burst (s_axi_awburst),
        .advance     (w_hs),
        .word        (wgen_word),
        .last        (wgen_last)
    );

    axi4_addr_gen #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .WORD_LSB   (WORD_LSB),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_rd_addr_gen (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .load        (ar_hs),
        .start_addr  (s_axi_araddr),
        .start_len   (s_axi_arlen),
        .start_size  (s_axi_arsize),
        .start_burst (s_axi_arburst),
        .advance     (ren),
        .word        (rgen_word),
        .last        (rgen_last)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_reg   <= W_IDLE;
            werr_reg      <= 1'b0;
            wlast_err_reg <= 1'b0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= OKAY;
            bid_reg       <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_state_reg   <= W_DATA;
                        werr_reg      <= !burst_legal(s_axi_awburst, s_axi_awlen, s_axi_awsize, MAX_SIZE);
                        wlast_err_reg <= 1'b0;
                        bid_reg       <= s_axi_awid;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (wgen_last) begin
                            w_state_reg <= W_RESP;
                            bvalid_reg  <= 1'b1;
                            bresp_reg   <= (werr_reg || wlast_err_reg || wlast_bad) ? SLVERR : OKAY;
                        end else if (wlast_bad) begin
                            wlast_err_reg <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state_reg <= W_IDLE;
                        bvalid_reg  <= 1'b0;
                        bresp_reg   <= OKAY;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state_reg <= R_IDLE;
            rerr_reg    <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= OKAY;
            rlast_reg   <= 1'b0;
            rid_reg     <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_reg <= R_FETCH;
                        rerr_reg    <= !burst_legal(s_axi_arburst, s_axi_arlen, s_axi_arsize, MAX_SIZE);
                        rid_reg     <= s_axi_arid;
                    end
                end
                R_FETCH: begin
                    r_state_reg <= R_DATA;
                    rvalid_reg  <= 1'b1;
                    rlast_reg   <= rgen_last;
                    rresp_reg   <= rerr_reg ? SLVERR : OKAY;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (rlast_reg) begin
                            r_state_reg <= R_IDLE;
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            rresp_reg   <= OKAY;
                        end else begin
                            rlast_reg <= rgen_last;
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // One narrow RAM per byte lane gives clean byte-enable block RAM inference.
    genvar gi;
    generate
        for (gi = 0; gi < AXI_STROBE_WIDTH; gi++) begin : g_lane
            logic [7:0] mem_lane [MEM_DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge s_axi_aclk) begin
                if (wen && s_axi_wstrb[gi]) begin
                    mem_lane[wgen_word] <= s_axi_wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge s_axi_aclk) begin
                if (ren) begin
                    q_reg <= mem_lane[rgen_word];
                end
            end

            assign ram_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Directed bench for axi4_burst_ram_slave: tasks drive AW/W/AR and push
// expected B/R responses; negedge monitors pop and compare on each handshake.
module tb_axi4_burst_ram_slave;
    import axi4_pkg::*;

    typedef struct {
        logic [15:0] id;
        logic [1:0]  resp;
    } b_exp_t;

    typedef struct {
        logic [15:0]  id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } r_exp_t;

    logic         s_axi_aclk;
    logic         s_axi_aresetn;
    logic [31:0]  s_axi_awaddr;
    logic [15:0]  s_axi_awid;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [127:0] s_axi_wdata;
    logic [15:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [15:0]  s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [31:0]  s_axi_araddr;
    logic [15:0]  s_axi_arid;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [15:0]  s_axi_rid;
    logic [127:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;

    int total = 0;
    int bad   = 0;

    b_exp_t       b_q[$];
    r_exp_t       r_q[$];
    logic [127:0] wd[16];
    logic [15:0]  ws[16];
    logic         stall_prev = 1'b0;
    logic [146:0] snap = '0;

    localparam logic [127:0] ONES     = {128{1'b1}};
    localparam logic [127:0] STRB_EXP = {{120{1'b1}}, 8'h00};
    localparam logic [127:0] T1_DATA  = 128'h0123456789ABCDEF0123456789ABCDEF;

    axi4_burst_ram_slave dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arid    (s_axi_arid),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=time limit reached required=test completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic push_r(input logic [15:0] id, input logic [127:0] data, input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endtask

    task automatic b_monitor();
        b_exp_t e;
        if (s_axi_aresetn && s_axi_bvalid && s_axi_bready) begin
            if (b_q.size() == 0) begin
                check("b_unexpected", 256'(b_q.size()), 256'(1));
            end else begin
                e = b_q.pop_front();
                check("b_resp", 256'({s_axi_bid, s_axi_bresp}), 256'({e.id, e.resp}));
            end
        end
    endtask

    task automatic r_monitor();
        r_exp_t e;
        if (!s_axi_aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && s_axi_rvalid)
                check("r_stall_hold", 256'({s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata}), 256'(snap));
            if (s_axi_rvalid && s_axi_rready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 256'(r_q.size()), 256'(1));
                end else begin
                    e = r_q.pop_front();
                    check("r_beat", 256'({s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata}),
                          256'({e.id, e.resp, e.last, e.data}));
                end
            end
            stall_prev = s_axi_rvalid && !s_axi_rready;
            snap       = {s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata};
        end
    endtask

    always @(negedge s_axi_aclk) b_monitor();
    always @(negedge s_axi_aclk) r_monitor();

    task automatic aw_issue(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        bit hs;
        s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge s_axi_aclk);
            hs = s_axi_awready;
            tick();
            n++;
        end
        s_axi_awvalid = 1'b0;
        check("aw_handshake", 256'(hs), 256'(1));
    endtask

    task automatic w_beat(input logic [127:0] d, input logic [15:0] s, input bit last);
        int n;
        bit hs;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge s_axi_aclk);
            hs = s_axi_wready;
            tick();
            n++;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        check("w_handshake", 256'(hs), 256'(1));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int wlast_at, input logic [1:0] exp_resp);
        b_exp_t e;
        int n;
        e.id = id; e.resp = exp_resp;
        b_q.push_back(e);
        aw_issue(addr, id, len, 3'd4, burst);
        for (int i = 0; i <= int'(len); i++) w_beat(wd[i], ws[i], i == wlast_at);
        n = 0;
        while (b_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("b_arrival", 256'(b_q.size()), 256'(0));
        $display("write addr=%h id=%0d len=%0d burst=%0d expect bresp=%0d", addr, id, len, burst, exp_resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle, input bit check_lat);
        int  n;
        int  first;
        bit  hs;
        bit  done;
        bit  ph;
        s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = len;
        s_axi_arsize = 3'd4; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge s_axi_aclk);
            hs = s_axi_arready;
            tick();
            n++;
        end
        s_axi_arvalid = 1'b0;
        check("ar_handshake", 256'(hs), 256'(1));
        done = 1'b0; n = 0; ph = 1'b0; first = -1;
        while (!done && n < 600) begin
            s_axi_rready = toggle ? ph : 1'b1;
            ph = !ph;
            @(negedge s_axi_aclk);
            if (s_axi_rvalid && first < 0) first = n;
            if (s_axi_rvalid && s_axi_rready && s_axi_rlast) done = 1'b1;
            tick();
            n++;
        end
        s_axi_rready = 1'b0;
        check("r_rlast_seen", 256'(done), 256'(1));
        if (check_lat) check("r_latency", 256'(first), 256'(1));
        check("r_q_drained", 256'(r_q.size()), 256'(0));
        $display("read  addr=%h id=%0d len=%0d burst=%0d toggle=%0d beats=%0d", addr, id, len, burst, toggle, int'(len) + 1);
    endtask

    task automatic check_all_idle(input string name);
        check(name, 256'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_bid,
                          s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rlast, s_axi_rid, s_axi_rdata}),
              256'(0));
    endtask

    initial begin
        s_axi_aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wd[i] = '0;
            ws[i] = '1;
        end

        repeat (3) tick();
        check_all_idle("reset_outputs");
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);
        check("ready_first_cycle", 256'({s_axi_awready, s_axi_arready}), 256'(2'b00));
        tick();
        check("ready_after_release", 256'({s_axi_awready, s_axi_arready}), 256'(2'b11));

        // single INCR beat, with read latency check
        wd[0] = T1_DATA;
        do_write(32'h10, 16'd1, 8'd0, INCR, 0, OKAY);
        push_r(16'd2, T1_DATA, OKAY, 1'b1);
        do_read(32'h10, 16'd2, 8'd0, INCR, 1'b0, 1'b1);

        // INCR len 3, readback with rready toggling
        for (int i = 0; i < 4; i++) wd[i] = 128'(i + 1);
        do_write(32'h00, 16'd3, 8'd3, INCR, 3, OKAY);
        for (int i = 0; i < 4; i++) push_r(16'd4, 128'(i + 1), OKAY, i == 3);
        do_read(32'h00, 16'd4, 8'd3, INCR, 1'b1, 1'b0);

        // WRAP len 3 from 0x30 visits 0x30,0x00,0x10,0x20
        push_r(16'd5, 128'd4, OKAY, 1'b0);
        push_r(16'd5, 128'd1, OKAY, 1'b0);
        push_r(16'd5, 128'd2, OKAY, 1'b0);
        push_r(16'd5, 128'd3, OKAY, 1'b1);
        do_read(32'h30, 16'd5, 8'd3, WRAP, 1'b0, 1'b0);

        // FIXED len 1 repeats the same word
        push_r(16'd6, 128'd2, OKAY, 1'b0);
        push_r(16'd6, 128'd2, OKAY, 1'b1);
        do_read(32'h10, 16'd6, 8'd1, FIXED, 1'b1, 1'b0);

        // byte strobes
        wd[0] = ONES; ws[0] = '1;
        do_write(32'h40, 16'd7, 8'd0, INCR, 0, OKAY);
        wd[0] = '0; ws[0] = 16'h0001;
        do_write(32'h40, 16'd8, 8'd0, INCR, 0, OKAY);
        ws[0] = '1;
        push_r(16'd9, STRB_EXP, OKAY, 1'b1);
        do_read(32'h40, 16'd9, 8'd0, INCR, 1'b0, 1'b0);

        // reserved burst type: SLVERR, nothing written
        wd[0] = 128'h1234; wd[1] = 128'h5678;
        do_write(32'h40, 16'd10, 8'd1, 2'b11, 1, SLVERR);
        push_r(16'd11, STRB_EXP, OKAY, 1'b1);
        do_read(32'h40, 16'd11, 8'd0, INCR, 1'b0, 1'b0);

        // WRAP with illegal len 2: three zero beats with SLVERR
        for (int i = 0; i < 3; i++) push_r(16'd12, 128'd0, SLVERR, i == 2);
        do_read(32'h00, 16'd12, 8'd2, WRAP, 1'b0, 1'b0);

        // early wlast: SLVERR but data still lands
        for (int i = 0; i < 4; i++) wd[i] = 128'hC0 + 128'(i);
        do_write(32'hC0, 16'd13, 8'd3, INCR, 1, SLVERR);
        for (int i = 0; i < 4; i++) push_r(16'd14, 128'hC0 + 128'(i), OKAY, i == 3);
        do_read(32'hC0, 16'd14, 8'd3, INCR, 1'b0, 1'b0);

        // reset in the middle of a write burst
        for (int i = 0; i < 4; i++) wd[i] = 128'hA0 + 128'(i);
        do_write(32'h80, 16'd15, 8'd3, INCR, 3, OKAY);
        aw_issue(32'h80, 16'd16, 8'd3, 3'd4, INCR);
        w_beat(128'hB0, '1, 1'b0);
        w_beat(128'hB1, '1, 1'b0);
        s_axi_aresetn = 1'b0;
        #1;
        check_all_idle("midburst_reset_outputs");
        $display("reset asserted after 2 of 4 write beats");
        tick();
        tick();
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);
        check("awready_first_cycle", 256'(s_axi_awready), 256'(0));
        tick();
        check("awready_after_release", 256'(s_axi_awready), 256'(1));
        push_r(16'd17, 128'hB0, OKAY, 1'b0);
        push_r(16'd17, 128'hB1, OKAY, 1'b0);
        push_r(16'd17, 128'hA2, OKAY, 1'b0);
        push_r(16'd17, 128'hA3, OKAY, 1'b1);
        do_read(32'h80, 16'd17, 8'd3, INCR, 1'b0, 1'b0);

        check("b_q_empty", 256'(b_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_burst_ram_slave.md
# axi4_burst_ram_slave

Synthesizable, parametrised AXI4 slave that backs a block RAM and supports full bursts (FIXED/INCR/WRAP, any len 0–255, narrow sizes, byte strobes) on independent read and write paths. It serves as the on-chip memory target for the PS/PL AXI interconnect in the photonic-ML data path. It is also the DUT that the single-beat AXI bench write/read tasks are upgraded to exercise with bursts.

## Interface
- AXI_ADDR_WIDTH, 32, byte-address width
- AXI_DATA_WIDTH, 128, data width; power of two, 32..512
- AXI_ID_WIDTH, 16, ID width
- MEM_DEPTH, 256, RAM words; power of two
- AXI_STROBE_WIDTH, AXI_DATA_WIDTH/8, derived; not overridden
- s_axi_aclk  in  1  clock; the block uses this single clock
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- s_axi_awaddr/awid/awlen/awsize/awburst  in  ADDR/ID/8/3/2  write address
- s_axi_awvalid in 1, s_axi_awready out 1
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA/STROBE/1/1, s_axi_wready out 1
- s_axi_bid/bresp/bvalid  out  ID/2/1, s_axi_bready in 1
- s_axi_araddr/arid/arlen/arsize/arburst  in  ADDR/ID/8/3/2  read address
- s_axi_arvalid in 1, s_axi_arready out 1
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID/DATA/2/1/1, s_axi_rready in 1

## Operation
- Word index = byte_addr[$clog2(STROBE_WIDTH) +: $clog2(MEM_DEPTH)]. Upper address bits are ignored, so the RAM aliases.
- Address step per beat = 1<<size bytes. FIXED keeps the address; INCR adds the step.
- WRAP: len must be 1/3/7/15. The wrap boundary is (len+1)<<size bytes, aligned to that size.
- The following are errors: burst 2'b11, WRAP with any other len, or size > log2(STROBE_WIDTH).
  - An errored write consumes all beats but writes nothing; bresp = SLVERR (2'b10).
  - An errored read returns len+1 beats with rdata 0 and rresp SLVERR.
- The burst length comes from the internal beat counter, not from wlast.
  - wlast on a non-final beat, or missing on the final beat, sets bresp SLVERR. Data beats are still written.
- Write FSM: W_IDLE (awready=1) → W_DATA (wready=1; each wvalid&wready writes bytes where wstrb=1) → W_RESP (bvalid=1 until bready) → W_IDLE.
- Read FSM: R_IDLE (arready=1) → R_FETCH (RAM read issued) → R_DATA (rvalid=1). R_DATA returns to R_IDLE after the rlast handshake.
- bid/rid echo awid/arid, which are latched at address handshake.
- The read and write paths are fully independent. Same-word read and write on the same edge: the read returns old data.
- RAM contents are not reset.

## Timing
- Reset values: all ready/valid = 0, bresp/rresp = 0, rlast = 0, bid/rid/rdata = 0.
- A rst_done flop clears on reset and sets on the first edge after release. awready/arready = state==IDLE & rst_done, so both rise one cycle after release.
- Write timing:
  - AW handshake at edge N → wready from N+1.
  - The final W beat at edge M → bvalid from M+1.
  - B handshake at edge K → awready at K+1.
- Read timing:
  - AR handshake at edge N → R_FETCH in N+1 → rvalid with beat 0 from N+2.
  - After that, one beat per cycle while rready=1. The next RAM address is muxed in when the handshake occurs.
  - While rvalid & !rready, rdata/rresp/rlast/rid are held stable.
- rlast = 1 exactly on beat len. With len=0, rlast is set on the first beat.
- Reset asserted mid-burst: outputs go to reset values immediately and FSMs return to IDLE. The transaction is dropped; beats already written remain in RAM.

## Structure
- Package axi4_pkg contains:
  - burst_t enum (FIXED=0, INCR=1, WRAP=2)
  - resp constants OKAY=2'b00, SLVERR=2'b10
  - function burst_legal(burst, len, size)
- Sub-module axi4_addr_gen (one instance per path): loads start addr/len/size/burst, outputs the current address, steps on advance, and flags last.
- RAM is inferred as simple dual-port (one write port, one read port) with a registered read and byte enables.

## Test plan
- Single INCR beat: write 0x10 with data 0x0123…CDEF, wstrb all-1 → bresp 00. Read 0x10 → same data, rresp 00, rlast on beat 0, rvalid 2 cycles after AR handshake.
- INCR len=3 write at 0x00 with words 1,2,3,4. Read back with rready toggling every cycle → 1,2,3,4 in order, rdata stable during stalls, rlast only on the 4th beat.
- WRAP len=3 size=4 read at 0x30 after writing 0x00–0x3F → address order 0x30,0x00,0x10,0x20, rresp 00.
- Strobes: write all-F to 0x40, then write data 0 with wstrb=0x0001 → readback 0xFFFF…FF00.
- Errors, in order:
  - awburst=2'b11, len 1 → bresp 10, RAM unchanged.
  - WRAP len=2 read → 3 beats of rdata 0, rresp 10.
  - wlast early on an INCR len=3 write → bresp 10.
- Reset asserted after 2 of 4 W beats → all valid/ready outputs 0 immediately. awready=1 one cycle after release; beats 0–1 are present in RAM, beats 2–3 are untouched.
